// File: rtl/sar_arbiter.sv
// Round-robin arbiter sharing one SAR FSM/datapath pair among N requesters,
// with a per-operation watchdog that aborts a hung conversion.
module sar_arbiter #(
  parameter int N   = 4,
  parameter int W   = 16,
  parameter int TMO = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         dp_stp,
  output logic         dp_abort,
  input  logic         dp_eop,
  input  logic [W-1:0] dp_res,
  output logic [W-1:0] res,
  output logic [N-1:0] done,
  output logic [N-1:0] err,
  output logic         busy
);

  localparam int         PW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] TMO_C = 8'(TMO);

  typedef enum logic [2:0] {IDLE, START, WAIT, RUN, DONE, ABORT} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    wdt_q, wdt_d;
  logic [W-1:0]  res_q, res_d;

  logic [PW-1:0] win_idx;
  logic          win_vld;
  logic [PW-1:0] own_idx;
  int unsigned   cand;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (32'(ptr_q) + 32'(k)) % 32'(N);
      if (!win_vld && req[cand[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    own_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) own_idx = PW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wdt_d   = wdt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld && dp_eop) begin
          gnt_d[win_idx] = 1'b1;
          state_d        = START;
        end
      end
      START: begin
        wdt_d   = '0;
        state_d = WAIT;
      end
      // Watchdog expiry outranks any dp_eop activity in the same cycle.
      WAIT: begin
        if (wdt_q == TMO_C) begin
          state_d = ABORT;
        end else begin
          wdt_d = wdt_q + 8'd1;
          if (!dp_eop) state_d = RUN;
        end
      end
      RUN: begin
        if (wdt_q == TMO_C) begin
          state_d = ABORT;
        end else begin
          wdt_d = wdt_q + 8'd1;
          if (dp_eop) begin
            res_d   = dp_res;
            state_d = DONE;
          end
        end
      end
      DONE, ABORT: begin
        ptr_d   = own_idx;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= PW'(N - 1);
      wdt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wdt_q   <= wdt_d;
      res_q   <= res_d;
    end
  end

  assign gnt      = gnt_q;
  assign res      = res_q;
  assign dp_stp   = (state_q == START);
  assign dp_abort = (state_q == ABORT);
  assign done     = (state_q == DONE)  ? gnt_q : '0;
  assign err      = (state_q == ABORT) ? gnt_q : '0;
  assign busy     = (state_q != IDLE);

endmodule
